// File: rtl/counter_disp_pkg.sv
// Shared types and constants for the counter display driver.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits.
package counter_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Active-low segments {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Smallest digit count with 10^d > 2^w
  function automatic int digits_for(input int w);
    longint p;
    longint lim;
    int d;
    p = 1;
    lim = longint'(1) << w;
    d = 0;
    while (p <= lim) begin
      p = p * 10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Non-decimal values and blanked digits drive all segments off.
module seg7_dec
  import counter_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/counter_disp_drv.sv
// Binary to BCD (double-dabble) plus multiplexed 7-seg display driver.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module counter_disp_drv
  import counter_disp_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = digits_for(WIDTH),
  parameter int REFRESH_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_vld,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] bin, bin_n;
  logic [BW-1:0]    acc, acc_n, adj, bcd_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             vld_n;

  always_comb begin
    state_n = state;
    bin_n   = bin;
    acc_n   = acc;
    cnt_n   = cnt;
    bcd_n   = bcd;
    vld_n   = 1'b0;
    adj     = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    unique case (state)
      IDLE: begin
        bin_n   = din;
        acc_n   = '0;
        cnt_n   = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        {acc_n, bin_n} = {adj, bin} << 1;
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1))
          state_n = DONE;
      end
      DONE: begin
        bcd_n   = acc;
        vld_n   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bin     <= '0;
      acc     <= '0;
      cnt     <= '0;
      bcd     <= '0;
      bcd_vld <= 1'b0;
    end else begin
      state   <= state_n;
      bin     <= bin_n;
      acc     <= acc_n;
      cnt     <= cnt_n;
      bcd     <= bcd_n;
      bcd_vld <= vld_n;
    end
  end

  logic [RW-1:0]     rcnt;
  logic [IW-1:0]     idx;
  logic [3:0]        digit;
  logic              blank;
  logic [6:0]        seg_d;
  logic [DIGITS-1:0] an_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
      rcnt <= '0;
      idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  always_comb begin
    digit = '0;
    an_d  = '1;
    blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        digit   = bcd[4*i +: 4];
        an_d[i] = 1'b0;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    // Blank unless some digit at or above idx is nonzero
    blank = (idx != '0);
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) >= idx && bcd[4*i +: 4] != 4'd0)
        blank = 1'b0;
    end
`endif
  end

  seg7_dec u_dec (
    .digit (digit),
    .blank (blank),
    .seg   (seg_d)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= an_d;
      seg <= seg_d;
    end
  end

endmodule

// File: doc/counter_disp_drv.md
Name: counter_disp_drv

Overview:
- Downstream display stage for the 8-bit up/down counter.
- Takes the counter's binary `dout` on `din`, converts it to packed BCD with a sequential shift-add-3 (double-dabble) engine, and drives a time-multiplexed, active-low, common-anode 7-segment display.
- Free-running: it reconverts the latest `din` continuously, so the display tracks the counter.

Parameters:
- WIDTH, 8: binary input width. Must equal the counter width.
- DIGITS, 3: number of BCD digits and anodes. Must satisfy 10^DIGITS > 2^WIDTH.
- REFRESH_DIV, 4: clock cycles each digit stays lit. 4 for simulation; 50000 on board.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately on assertion.
- din  in  WIDTH  binary value from the counter's `dout`.
- bcd  out  4*DIGITS  last completed BCD result; digit 0 in bits [3:0].
- bcd_vld  out  1  one-cycle pulse in the cycle after `bcd` updates.
- an  out  DIGITS  anode selects, active-low, one-hot-zero.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset values (rst=0):
  - FSM=IDLE, bcd=0, bcd_vld=0.
  - Scan index=0, refresh count=0.
  - an=all ones, seg=7'h7F (display dark).
- FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: load bin<=din, acc<=0, cnt<=0; go to SHIFT. Executes on the first edge after reset release.
  - SHIFT: each cycle, add 3 to every acc nibble >= 5, then shift {acc,bin} left by 1; cnt++. When cnt==WIDTH-1 (WIDTH shifts done), go to DONE.
  - DONE: bcd<=acc, bcd_vld<=1; go to IDLE.
  - In all other cycles bcd_vld<=0.
- Timing:
  - `din` is sampled at edge k; `bcd` is updated at edge k+WIDTH+1.
  - Conversion period is WIDTH+2 cycles (10 at default).
- `din` changes between samples are ignored. The conversion in flight always completes with the value captured in IDLE.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On the wrap, scan index increments and wraps DIGITS-1 -> 0.
- `an` and `seg` are registered from the current scan index and `bcd`:
  - an <= ~(1<<idx).
  - seg <= decode(bcd digit idx).
- Decode table: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Any value 10-15 decodes to 7F.
- `bcd` changing mid-scan takes effect on the next registered `seg` update; no tearing suppression.
- Reset asserted mid-operation:
  - All state returns to reset values asynchronously and the conversion in flight is discarded.
  - After release, the first bcd_vld appears WIDTH+2 cycles later.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: any digit above the most significant nonzero digit drives seg=7F. Digit 0 always displays, so a value of 0 shows "0".
- Undefined: all digits display, including leading zeros (digit value 0 -> 40).

Decomposition:
- Shared package counter_disp_pkg holds:
  - FSM state encodings: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - The ten segment constants plus SEG_BLANK=7'h7F.
  - The DIGITS-for-WIDTH sizing rule.
- One sub-module: seg7_dec, a combinational 4-bit BCD to 7-segment decoder.
- Scan mux and FSM stay in the top level.

Test Plan:
- Reset: hold rst=0 for 3 cycles with din=8'hFF -> an=3'b111, seg=7'h7F, bcd=12'h000, bcd_vld=0 throughout.
- Full scale: release rst with din=8'hFF held -> bcd=12'h255 with the first bcd_vld 10 cycles after release; then bcd_vld repeats every 10 cycles; no other pulses.
- Scan decode with din=8'd156 -> bcd=12'h156. Each refresh period shows one digit in turn:
  - an=110, seg=02
  - an=101, seg=12
  - an=011, seg=79
  - then repeats.
- Blanking with din=8'd81:
  - LEADING_ZERO_BLANK_EN defined -> an=011 shows seg=7F.
  - Undefined -> an=011 shows seg=40.
  - Both builds -> an=101 shows 00, an=110 shows 79.
- Mid-conversion change: din=0, then din=200 in the 3rd SHIFT cycle -> the current result completes as bcd=12'h000; the next conversion gives bcd=12'h200.
- Reset mid-SHIFT: pulse rst low for 1 cycle -> outputs return to reset values immediately; the first bcd_vld after release appears 10 cycles later with the correct value.
